burst_capture_ctrl: RTL and testbench
=====================================

Name: burst_capture_ctrl

Overview:
- Single-clock capture controller for the hardware test harness. Collects per-cycle DUT result words and packs burst_index words into one wide RAM line. Writes each line to on-chip RAM at an auto-incrementing address.
- Successor to the fixed burst/shift-register transfer logic. Adds:
  - parametrised word width, burst depth and RAM depth;
  - single-shot or circular capture mode;
  - stop-triggered flush of a partial line;
  - fill/wrap status for the readback controller.

Parameters:
- word_bits, 33: width of one DUT result word, equal to (no_of_digits+1)*radix_bits.
- burst_index, 5: words packed per RAM line; must be >= 2.
- address_width, 12: RAM address width.
- max_ram_address, 4096: number of RAM lines; must be <= 2^address_width.

Ports:
- clk  in  1: single clock; all logic on posedge.
- reset  in  1: synchronous, active-high.
- start  in  1: one-cycle pulse; arms a capture from IDLE or DONE.
- mode_circular  in  1: sampled on start. 0 = single-shot, 1 = circular.
- stop  in  1: ends capture, with flush, while busy.
- din  in  word_bits: DUT result word.
- din_valid  in  1: din is accepted this cycle (only while capture_en=1).
- capture_en  out  1: high in CAPTURE. Drives the LFSR/DUT clock enable.
- ram_addr  out  address_width: write address.
- ram_data  out  word_bits*burst_index: packed line.
- ram_wren  out  1: one-cycle write strobe.
- busy  out  1: high in CAPTURE or FLUSH.
- done  out  1: high in DONE.
- wrapped  out  1: circular capture has overwritten address 0 at least once.
- lines_written  out  address_width+1: lines written, saturating at max_ram_address.

Behaviour:
- Reset (any state, mid-operation included):
  - state=IDLE;
  - capture_en, ram_wren, busy, done and wrapped = 0;
  - ram_addr, ram_data, lines_written, pack counter and pack buffer = 0.
- States: IDLE, CAPTURE, FLUSH, DONE.
  - IDLE -start-> CAPTURE.
  - DONE -start-> CAPTURE. Clears ram_addr, lines_written, wrapped and pack counter on entry.
  - start while busy is ignored.
- Packing:
  - Pack counter k runs 0..burst_index-1.
  - An accepted word lands in buffer bits [(k+1)*word_bits-1 : k*word_bits]. Word 0 is the LSB slice.
  - When k = burst_index-1 is accepted:
    - ram_data is loaded with the full line;
    - ram_wren=1 on the next cycle (latency 1), with ram_addr = current line address;
    - k returns to 0.
  - The address increments in the cycle after the strobe.
- Address end, single-shot:
  - After the write to max_ram_address-1, go to DONE. capture_en drops in the same cycle ram_wren is high.
  - No further words are accepted.
- Address end, circular:
  - After max_ram_address-1, ram_addr wraps to 0.
  - wrapped is set on the first write to address 0 following a wrap.
  - Capture continues until stop.
- stop in CAPTURE:
  - A word with din_valid in the same cycle is accepted first.
  - If k>0 afterwards, go to FLUSH. Unfilled slices are zero. One ram_wren is issued, then DONE.
  - If k=0 afterwards, go to DONE directly.
  - If that word completed a line, the line is written normally and no extra flush occurs.
- stop outside CAPTURE is ignored.
- din_valid outside CAPTURE is ignored.
- capture_en is 0 in FLUSH.
- lines_written increments on every ram_wren and saturates at max_ram_address.
- ram_wren is never high for two lines at the same address without an intervening wrap.

Test Plan:
Parameters for all scenarios: word_bits=8, burst_index=3, address_width=2, max_ram_address=4.
- Single-shot fill:
  - Stimulus: start with mode 0, then 12 valid words 0x01..0x0C.
  - Response: four writes, one cycle after each third word:
    - addr0=0x030201
    - addr1=0x060504
    - addr2=0x090807
    - addr3=0x0C0B0A
  - Then done=1, lines_written=4 and capture_en=0. A 13th word is not accepted.
- Gaps in din_valid:
  - Stimulus: alternate din_valid 1/0 over 6 words.
  - Response: exactly 2 writes with the correct packing. No write on invalid cycles.
- Circular wrap:
  - Stimulus: mode 1, 15 words 0x01..0x0F, then stop.
  - Response:
    - fifth write at addr0=0x0F0E0D;
    - wrapped=1;
    - lines_written saturated at 4;
    - DONE with no flush.
- Partial flush:
  - Stimulus: mode 0, 4 words 0xA1..0xA4, with stop in the same cycle as the fourth word.
  - Response:
    - addr0=0xA3A2A1;
    - FLUSH writes addr1=0x0000A4;
    - done=1, lines_written=2.
- Reset mid-capture and restart:
  - Stimulus: assert reset after 5 words, then start again.
  - Response:
    - all outputs at reset values the cycle after reset;
    - the new capture starts at addr0 with k=0;
    - start while busy is ignored;
    - start in DONE clears the counters.

Source files
------------

// File: rtl/burst_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : burst_capture_ctrl
//  Purpose  : Packs per-cycle DUT result words into wide RAM lines and writes
//             them at an auto-incrementing address (single-shot or circular).
//  Revision : 1.0  initial release
// ============================================================================
module burst_capture_ctrl #(
  parameter int WORD_BITS       = 33,
  parameter int BURST_INDEX     = 5,
  parameter int ADDRESS_WIDTH   = 12,
  parameter int MAX_RAM_ADDRESS = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_start,
  input  logic                             i_mode_circular,
  input  logic                             i_stop,
  input  logic [WORD_BITS-1:0]             i_din,
  input  logic                             i_din_valid,
  output logic                             o_capture_en,
  output logic [ADDRESS_WIDTH-1:0]         o_ram_addr,
  output logic [WORD_BITS*BURST_INDEX-1:0] o_ram_data,
  output logic                             o_ram_wren,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_wrapped,
  output logic [ADDRESS_WIDTH:0]           o_lines_written
);

  localparam int c_KW = (BURST_INDEX > 1) ? $clog2(BURST_INDEX) : 1;
  localparam int c_LW = WORD_BITS * BURST_INDEX;
  localparam logic [c_KW-1:0]          c_K_LAST    = c_KW'(BURST_INDEX - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_LAST = ADDRESS_WIDTH'(MAX_RAM_ADDRESS - 1);
  localparam logic [ADDRESS_WIDTH:0]   c_LINES_MAX = (ADDRESS_WIDTH + 1)'(MAX_RAM_ADDRESS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                   r_state, w_next;
  logic [c_KW-1:0]          r_k;
  logic [c_LW-1:0]          r_buf, w_buf_next, r_data;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_lines;
  logic                     r_wren, r_circ, r_wrapped, r_wrap_pend;
  logic                     w_accept, w_line_full, w_last_addr, w_arm, w_k_pending;

  always_comb begin
    w_accept    = (r_state == S_CAPTURE) && i_din_valid;
    w_line_full = w_accept && (r_k == c_K_LAST);
    w_last_addr = (r_addr == c_ADDR_LAST);
    w_arm       = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Words left in the buffer after this cycle's accept decide whether stop needs a flush
    w_k_pending = !w_line_full && (w_accept || (r_k != '0));
    w_buf_next  = r_buf;
    if (w_accept) begin
      w_buf_next[int'(r_k)*WORD_BITS +: WORD_BITS] = i_din;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (w_line_full && !r_circ && w_last_addr) begin
          w_next = S_DONE;
        end else if (i_stop) begin
          w_next = w_k_pending ? S_FLUSH : S_DONE;
        end
      end
      S_FLUSH:   w_next = S_DONE;
      S_DONE:    if (i_start) w_next = S_CAPTURE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_buf       <= '0;
      r_data      <= '0;
      r_addr      <= '0;
      r_lines     <= '0;
      r_wren      <= 1'b0;
      r_circ      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wren  <= 1'b0;
      if (w_arm) begin
        r_circ      <= i_mode_circular;
        r_k         <= '0;
        r_buf       <= '0;
        r_addr      <= '0;
        r_lines     <= '0;
        r_wrapped   <= 1'b0;
        r_wrap_pend <= 1'b0;
      end else begin
        if (w_accept) begin
          if (w_line_full) begin
            r_data <= w_buf_next;
            r_wren <= 1'b1;
            r_k    <= '0;
            r_buf  <= '0;
            if (r_wrap_pend && (r_addr == '0)) r_wrapped <= 1'b1;
          end else begin
            r_buf <= w_buf_next;
            r_k   <= r_k + 1'b1;
          end
        end
        if (r_state == S_FLUSH) begin
          r_data <= r_buf;
          r_wren <= 1'b1;
          r_k    <= '0;
          r_buf  <= '0;
          if (r_wrap_pend && (r_addr == '0)) r_wrapped <= 1'b1;
        end
        // Address and line count advance in the cycle after each strobe
        if (r_wren) begin
          if (r_lines != c_LINES_MAX) r_lines <= r_lines + 1'b1;
          if (w_last_addr) begin
            if (r_circ) begin
              r_addr      <= '0;
              r_wrap_pend <= 1'b1;
            end
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
      end
    end
  end

  assign o_capture_en    = (r_state == S_CAPTURE);
  assign o_busy          = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
  assign o_done          = (r_state == S_DONE);
  assign o_ram_addr      = r_addr;
  assign o_ram_data      = r_data;
  assign o_ram_wren      = r_wren;
  assign o_wrapped       = r_wrapped;
  assign o_lines_written = r_lines;

endmodule
`default_nettype wire

// File: tb/tb_burst_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_burst_capture_ctrl
//  Purpose  : Scoreboard bench for burst_capture_ctrl (8-bit words, 3/line, 4 lines).
//  Revision : 1.0  initial release
// ============================================================================
module tb_burst_capture_ctrl;

  localparam int c_WB = 8;
  localparam int c_BI = 3;
  localparam int c_AW = 2;
  localparam int c_MAX = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_start = 1'b0, i_mode_circular = 1'b0, i_stop = 1'b0;
  logic [c_WB-1:0]      i_din = '0;
  logic                 i_din_valid = 1'b0;
  logic                 o_capture_en, o_ram_wren, o_busy, o_done, o_wrapped;
  logic [c_AW-1:0]      o_ram_addr;
  logic [c_WB*c_BI-1:0] o_ram_data;
  logic [c_AW:0]        o_lines_written;

  burst_capture_ctrl #(
    .WORD_BITS(c_WB), .BURST_INDEX(c_BI), .ADDRESS_WIDTH(c_AW), .MAX_RAM_ADDRESS(c_MAX)
  ) u_dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_mode_circular(i_mode_circular),
    .i_stop(i_stop), .i_din(i_din), .i_din_valid(i_din_valid),
    .o_capture_en(o_capture_en), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .o_ram_wren(o_ram_wren), .o_busy(o_busy), .o_done(o_done), .o_wrapped(o_wrapped),
    .o_lines_written(o_lines_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: {addr, data}
  logic [31:0] q_exp[$];
  logic [c_WB*c_BI-1:0] m_buf;
  int m_k, m_addr;
  bit m_active, m_circ;
  logic [c_AW-1:0]      last_addr;
  logic [c_WB*c_BI-1:0] last_data;

  always @(negedge clk) begin
    if (!reset && o_ram_wren) begin
      last_addr = o_ram_addr;
      last_data = o_ram_data;
      if (q_exp.size() == 0) begin
        chk("unexpected_write", {62'd0, o_ram_addr}, 64'hFFFF);
      end else begin
        logic [31:0] e;
        e = q_exp.pop_front();
        chk("wr_addr", {62'd0, o_ram_addr}, {62'd0, e[25:24]});
        chk("wr_data", {40'd0, o_ram_data}, {40'd0, e[23:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push();
    q_exp.push_back({6'd0, 2'(m_addr), m_buf});
    m_buf = '0;
    m_k   = 0;
    if (m_addr == c_MAX - 1) begin
      m_addr = 0;
      if (!m_circ) m_active = 0;
    end else begin
      m_addr++;
    end
  endtask

  task automatic do_start(input bit circ);
    i_start = 1'b1;
    i_mode_circular = circ;
    tick();
    i_start = 1'b0;
    m_active = 1; m_circ = circ; m_addr = 0; m_k = 0; m_buf = '0;
  endtask

  task automatic send(input logic [7:0] w, input bit v, input bit s);
    i_din = w;
    i_din_valid = v;
    i_stop = s;
    if (v && m_active) begin
      m_buf[m_k*c_WB +: c_WB] = w;
      m_k++;
      if (m_k == c_BI) model_push();
    end
    if (s && m_active) begin
      if (m_k > 0) model_push();
      m_active = 0;
    end
    tick();
    i_din_valid = 1'b0;
    i_stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    m_active = 0; m_circ = 0; m_k = 0; m_addr = 0; m_buf = '0;
    last_addr = '0; last_data = '0;
    idle(2);
    chk("rst_capture_en", {63'd0, o_capture_en}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_wren", {63'd0, o_ram_wren}, 64'd0);
    chk("rst_addr_data", {38'd0, o_ram_addr, o_ram_data}, 64'd0);
    chk("rst_lines_wrapped", {60'd0, o_lines_written, o_wrapped}, 64'd0);
    reset = 1'b0;
    tick();

    // Single-shot fill of all four lines, then a 13th word that must be dropped
    do_start(0);
    chk("ss_capture_en", {63'd0, o_capture_en}, 64'd1);
    chk("ss_busy", {63'd0, o_busy}, 64'd1);
    for (int i = 1; i <= 12; i++) send(8'(i), 1, 0);
    chk("ss_cap_en_drop", {63'd0, o_capture_en}, 64'd0);
    send(8'h0D, 1, 0);
    idle(3);
    chk("ss_done", {63'd0, o_done}, 64'd1);
    chk("ss_lines", {61'd0, o_lines_written}, 64'd4);
    chk("ss_last_line", {40'd0, last_data}, 64'h0C0B0A);
    chk("ss_q_empty", 64'(q_exp.size()), 64'd0);

    // Alternating valid: six words over twelve cycles
    do_start(0);
    chk("gap_addr_clr", {62'd0, o_ram_addr}, 64'd0);
    chk("gap_lines_clr", {61'd0, o_lines_written}, 64'd0);
    for (int i = 0; i < 12; i++) send(8'(8'h10 + i), (i % 2) == 0, 0);
    idle(3);
    chk("gap_lines", {61'd0, o_lines_written}, 64'd2);
    chk("gap_busy", {63'd0, o_busy}, 64'd1);
    chk("gap_q_empty", 64'(q_exp.size()), 64'd0);
    send(8'h00, 0, 1);
    idle(2);

    // Circular wrap: 15 words, fifth line overwrites address 0
    do_start(1);
    chk("circ_wrapped_clr", {63'd0, o_wrapped}, 64'd0);
    for (int i = 1; i <= 15; i++) send(8'(i), 1, 0);
    idle(2);
    chk("circ_wrapped", {63'd0, o_wrapped}, 64'd1);
    chk("circ_last_addr", {62'd0, last_addr}, 64'd0);
    chk("circ_last_data", {40'd0, last_data}, 64'h0F0E0D);
    send(8'h00, 0, 1);
    idle(3);
    chk("circ_done", {63'd0, o_done}, 64'd1);
    chk("circ_lines_sat", {61'd0, o_lines_written}, 64'd4);
    chk("circ_q_empty", 64'(q_exp.size()), 64'd0);

    // Partial flush: stop alongside the fourth word
    do_start(0);
    send(8'hA1, 1, 0);
    send(8'hA2, 1, 0);
    send(8'hA3, 1, 0);
    send(8'hA4, 1, 1);
    chk("fl_cap_en", {63'd0, o_capture_en}, 64'd0);
    chk("fl_busy", {63'd0, o_busy}, 64'd1);
    idle(3);
    chk("fl_done", {63'd0, o_done}, 64'd1);
    chk("fl_lines", {61'd0, o_lines_written}, 64'd2);
    chk("fl_addr", {62'd0, last_addr}, 64'd1);
    chk("fl_data", {40'd0, last_data}, 64'h0000A4);
    chk("fl_q_empty", 64'(q_exp.size()), 64'd0);

    // Reset mid-capture, restart, and a start pulse while busy
    do_start(0);
    for (int i = 1; i <= 5; i++) send(8'(8'h40 + i), 1, 0);
    reset = 1'b1;
    tick();
    chk("mr_busy", {63'd0, o_busy}, 64'd0);
    chk("mr_wren_done", {62'd0, o_ram_wren, o_done}, 64'd0);
    chk("mr_addr_data", {38'd0, o_ram_addr, o_ram_data}, 64'd0);
    chk("mr_lines", {61'd0, o_lines_written}, 64'd0);
    chk("mr_q_empty", 64'(q_exp.size()), 64'd0);
    reset = 1'b0;
    m_active = 0;
    tick();
    do_start(0);
    i_start = 1'b1;
    send(8'h21, 1, 0);
    i_start = 1'b0;
    send(8'h22, 1, 0);
    send(8'h23, 1, 0);
    idle(2);
    chk("rs_addr0_data", {40'd0, last_data}, 64'h232221);
    chk("rs_addr0", {62'd0, last_addr}, 64'd0);
    chk("rs_busy", {63'd0, o_busy}, 64'd1);
    chk("rs_q_empty", 64'(q_exp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
